sync_fifo_param: RTL

//  Parametrised successor of the team's single-clock synchronous FIFO. Adds arbitrary (non-power-of-2)

---
 rtl/sync_fifo_param.sv | 118 +++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with arbitrary depth, thresholds, FWFT and flush
module sync_fifo_param #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 7,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       rd_valid,
    output logic                       wr_ack,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             wr_acc;
    logic             rd_acc;

    // Pointers wrap explicitly so non-power-of-two depths work
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;

    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            wr_ack    <= wr_acc;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; zero while empty so reset state reads 0
            assign data_out = empty ? '0 : mem[rd_ptr];
            assign rd_valid = !empty;
        end else begin : g_reg
            logic [WIDTH-1:0] data_q;
            logic             valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        data_q <= mem[rd_ptr];
                    end
                end
            end

            assign data_out = data_q;
            assign rd_valid = valid_q;
        end
    endgenerate

endmodule
